// File: rtl/decoder_pkg.sv
// Shared decode-side types: ALU opcodes, register index, and the hazard
// controller's FSM state and scoreboard slot layout.
package decoder_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] reg_t;

    typedef enum logic [2:0] {
        op_none,
        op_add,
        op_sub,
        op_and,
        op_or,
        op_xor,
        op_sll,
        op_srl
    } alu_opcode_t;

    typedef enum logic {
        HZ_IDLE,
        HZ_FLUSH
    } hazard_state_t;

    typedef struct packed {
        logic valid;
        reg_t dst;
    } sb_slot_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Shift-register scoreboard of in-flight destination registers plus the
// RAW match against the decode sources.
//   clk, arstn      clock / async active-low reset
//   i_advance       shift the scoreboard this cycle (no downstream hold)
//   i_load_valid    the issuing instruction writes a register
//   i_load_dst      destination of the issuing instruction
//   i_src1, i_src2  decode source registers
//   o_hit           some checked slot writes one of the sources
module hazard_scoreboard
    import decoder_pkg::*;
#(
    parameter int PIPE_DEPTH  = 3,
    parameter int HAZ_DEPTH   = PIPE_DEPTH,
    parameter bit ZERO_REG_EN = 1'b1
) (
    input  logic clk,
    input  logic arstn,
    input  logic i_advance,
    input  logic i_load_valid,
    input  reg_t i_load_dst,
    input  reg_t i_src1,
    input  reg_t i_src2,
    output logic o_hit
);

    sb_slot_t r_slots [PIPE_DEPTH];
    logic     w_dst_zero;
    logic     w_src1_ok;
    logic     w_src2_ok;

    assign w_dst_zero = ZERO_REG_EN && (i_load_dst == '0);
    assign w_src1_ok  = !(ZERO_REG_EN && (i_src1 == '0));
    assign w_src2_ok  = !(ZERO_REG_EN && (i_src2 == '0));

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                r_slots[k] <= '0;
            end
        end else if (i_advance) begin
            // A non-issuing cycle loads valid=0, i.e. a bubble.
            r_slots[0] <= '{valid: i_load_valid && !w_dst_zero, dst: i_load_dst};
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                r_slots[k] <= r_slots[k-1];
            end
        end
    end

    // Only the youngest HAZ_DEPTH slots matter; older ones are forwarded.
    always_comb begin
        o_hit = 1'b0;
        for (int k = 0; k < HAZ_DEPTH; k++) begin
            if (r_slots[k].valid &&
                ((w_src1_ok && (r_slots[k].dst == i_src1)) ||
                 (w_src2_ok && (r_slots[k].dst == i_src2)))) begin
                o_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller between decode and register read: stalls decode
// on RAW conflicts, blocks issue for a penalty window after a branch, and
// keeps saturating stall / flush counters.
//   clk, arstn        clock / async active-low reset
//   decode_*_i        instruction presented by decode
//   reg_src1/2_i      sources, reg_dst_i destination
//   pipe_hold_i       downstream freeze
//   issue_o           instruction accepted this cycle
//   stall_o           RAW conflict blocks decode
//   flush_o           branch penalty window active
//   stall_cnt_o       cycles with stall_o high (saturating)
//   flush_cnt_o       flush windows entered (saturating)
module hazard_ctrl
    import decoder_pkg::*;
#(
    parameter int PIPE_DEPTH     = 3,
    parameter int HAZ_DEPTH      = PIPE_DEPTH,
    parameter int BRANCH_PENALTY = 3,
    parameter bit ZERO_REG_EN    = 1'b1,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             decode_valid_i,
    input  alu_opcode_t      decode_opcode_i,
    input  logic             decode_branch_i,
    input  reg_t             reg_src1_i,
    input  reg_t             reg_src2_i,
    input  reg_t             reg_dst_i,
    input  logic             pipe_hold_i,
    output logic             issue_o,
    output logic             stall_o,
    output logic             flush_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int CW = (BRANCH_PENALTY > 1) ? $clog2(BRANCH_PENALTY) : 1;

    hazard_state_t    r_state;
    hazard_state_t    w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_hit;
    logic             w_hazard;
    logic             w_issue;
    logic             w_writes;
    logic             w_flush_entry;

    hazard_scoreboard #(
        .PIPE_DEPTH  (PIPE_DEPTH),
        .HAZ_DEPTH   (HAZ_DEPTH),
        .ZERO_REG_EN (ZERO_REG_EN)
    ) u_scoreboard (
        .clk          (clk),
        .arstn        (arstn),
        .i_advance    (!pipe_hold_i),
        .i_load_valid (w_writes),
        .i_load_dst   (reg_dst_i),
        .i_src1       (reg_src1_i),
        .i_src2       (reg_src2_i),
        .o_hit        (w_hit)
    );

    assign w_hazard      = decode_valid_i && (decode_opcode_i != op_none) && w_hit;
    assign w_issue       = decode_valid_i && !w_hazard && !pipe_hold_i && (r_state == HZ_IDLE);
    assign w_writes      = w_issue && (decode_opcode_i != op_none);
    assign w_flush_entry = w_issue && decode_branch_i;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_state <= HZ_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            HZ_IDLE: begin
                if (w_flush_entry) begin
                    w_state_nxt = HZ_FLUSH;
                    w_cnt_nxt   = CW'(BRANCH_PENALTY - 1);
                end
            end
            HZ_FLUSH: begin
                if (!pipe_hold_i) begin
                    if (r_cnt == '0) begin
                        w_state_nxt = HZ_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
            end
            default: w_state_nxt = HZ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_hazard && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_entry && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign issue_o     = w_issue;
    assign stall_o     = w_hazard;
    assign flush_o     = (r_state == HZ_FLUSH);
    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
    import decoder_pkg::*;

    logic        clk;
    logic        arstn;
    logic        dv;
    alu_opcode_t op;
    logic        br;
    reg_t        s1, s2, dd;
    logic        hold;

    // a: defaults, b: HAZ_DEPTH=1, c: ZERO_REG_EN=0, d: CNT_W=4
    logic        a_iss, a_stl, a_fl;
    logic [15:0] a_scnt, a_fcnt;
    logic        b_iss, b_stl, b_fl;
    logic [15:0] b_scnt, b_fcnt;
    logic        c_iss, c_stl, c_fl;
    logic [15:0] c_scnt, c_fcnt;
    logic        d_iss, d_stl, d_fl;
    logic [3:0]  d_scnt, d_fcnt;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_ctrl u_a (
        .clk(clk), .arstn(arstn), .decode_valid_i(dv), .decode_opcode_i(op),
        .decode_branch_i(br), .reg_src1_i(s1), .reg_src2_i(s2), .reg_dst_i(dd),
        .pipe_hold_i(hold), .issue_o(a_iss), .stall_o(a_stl), .flush_o(a_fl),
        .stall_cnt_o(a_scnt), .flush_cnt_o(a_fcnt));

    hazard_ctrl #(.HAZ_DEPTH(1)) u_b (
        .clk(clk), .arstn(arstn), .decode_valid_i(dv), .decode_opcode_i(op),
        .decode_branch_i(br), .reg_src1_i(s1), .reg_src2_i(s2), .reg_dst_i(dd),
        .pipe_hold_i(hold), .issue_o(b_iss), .stall_o(b_stl), .flush_o(b_fl),
        .stall_cnt_o(b_scnt), .flush_cnt_o(b_fcnt));

    hazard_ctrl #(.ZERO_REG_EN(1'b0)) u_c (
        .clk(clk), .arstn(arstn), .decode_valid_i(dv), .decode_opcode_i(op),
        .decode_branch_i(br), .reg_src1_i(s1), .reg_src2_i(s2), .reg_dst_i(dd),
        .pipe_hold_i(hold), .issue_o(c_iss), .stall_o(c_stl), .flush_o(c_fl),
        .stall_cnt_o(c_scnt), .flush_cnt_o(c_fcnt));

    hazard_ctrl #(.CNT_W(4)) u_d (
        .clk(clk), .arstn(arstn), .decode_valid_i(dv), .decode_opcode_i(op),
        .decode_branch_i(br), .reg_src1_i(s1), .reg_src2_i(s2), .reg_dst_i(dd),
        .pipe_hold_i(hold), .issue_o(d_iss), .stall_o(d_stl), .flush_o(d_fl),
        .stall_cnt_o(d_scnt), .flush_cnt_o(d_fcnt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input alu_opcode_t o, input logic b,
                         input reg_t r1, input reg_t r2, input reg_t rd, input logic h);
        dv = v; op = o; br = b; s1 = r1; s2 = r2; dd = rd; hold = h;
    endtask

    task automatic idle();
        drive(1'b0, op_none, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    initial begin
        arstn = 1'b0;
        idle();
        #2;
        chk("rst_issue", a_iss, 0);
        chk("rst_stall", a_stl, 0);
        chk("rst_flush", a_fl, 0);
        chk("rst_scnt", a_scnt, 0);
        chk("rst_fcnt", a_fcnt, 0);

        // independent stream
        @(negedge clk); arstn = 1'b1;
        drive(1, op_add, 0, 5'd2, 5'd3, 5'd1, 0); #1;
        chk("ind_issue0", a_iss, 1);
        chk("ind_stall0", a_stl, 0);
        @(negedge clk); drive(1, op_add, 0, 5'd5, 5'd6, 5'd4, 0); #1;
        chk("ind_issue1", a_iss, 1);
        chk("ind_stall1", a_stl, 0);
        repeat (4) begin @(negedge clk); idle(); end
        #1 chk("ind_scnt", a_scnt, 0);

        // back-to-back RAW on r1
        @(negedge clk); drive(1, op_add, 0, 5'd2, 5'd3, 5'd1, 0); #1;
        chk("raw_wr_issue", a_iss, 1);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk); drive(1, op_add, 0, 5'd1, 5'd3, 5'd2, 0); #1;
            chk($sformatf("raw_stall_c%0d", i), a_stl, 1);
            chk($sformatf("raw_noissue_c%0d", i), a_iss, 0);
            if (i == 1) chk("fwd_stall_c1", b_stl, 1);
            if (i == 2) chk("fwd_issue_c2", b_iss, 1);
        end
        @(negedge clk); #1;
        chk("raw_issue_c4", a_iss, 1);
        chk("raw_nostall_c4", a_stl, 0);
        repeat (4) begin @(negedge clk); idle(); end
        #1;
        chk("raw_scnt", a_scnt, 3);
        chk("fwd_scnt", b_scnt, 1);
        chk("nz_scnt_raw", c_scnt, 3);

        // writer of r0 then reader of r0
        @(negedge clk); drive(1, op_add, 0, 5'd2, 5'd3, 5'd0, 0); #1;
        chk("r0_wr_issue", a_iss, 1);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk); drive(1, op_add, 0, 5'd0, 5'd6, 5'd5, 0); #1;
            if (i == 1) begin
                chk("r0_nostall", a_stl, 0);
                chk("r0_issue", a_iss, 1);
            end
            chk($sformatf("nz_stall_c%0d", i), c_stl, 1);
        end
        @(negedge clk); #1;
        chk("nz_issue_c4", c_iss, 1);
        repeat (4) begin @(negedge clk); idle(); end
        #1;
        chk("nz_scnt", c_scnt, 6);
        chk("r0_scnt", a_scnt, 3);

        // plain branch
        @(negedge clk); drive(1, op_none, 1, 5'd0, 5'd0, 5'd0, 0); #1;
        chk("br_issue", a_iss, 1);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk); drive(1, op_add, 0, 5'd8, 5'd9, 5'd7, 0); #1;
            chk($sformatf("br_flush_c%0d", i), a_fl, 1);
            chk($sformatf("br_block_c%0d", i), a_iss, 0);
            if (i == 1) chk("br_fcnt", a_fcnt, 1);
        end
        @(negedge clk); #1;
        chk("br_end_flush", a_fl, 0);
        chk("br_end_issue", a_iss, 1);
        repeat (4) begin @(negedge clk); idle(); end

        // branch with a 2-cycle hold inside the window
        @(negedge clk); drive(1, op_none, 1, 5'd0, 5'd0, 5'd0, 0); #1;
        chk("brh_issue", a_iss, 1);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk); idle(); hold = (i == 2 || i == 3); #1;
            chk($sformatf("brh_flush_c%0d", i), a_fl, 1);
        end
        @(negedge clk); idle(); #1;
        chk("brh_end_flush", a_fl, 0);
        chk("brh_fcnt", a_fcnt, 2);
        repeat (2) begin @(negedge clk); idle(); end

        // dependent branch: stall, issue, flush, then reset mid-window
        @(negedge clk); drive(1, op_add, 0, 5'd1, 5'd2, 5'd10, 0); #1;
        chk("dbr_wr_issue", a_iss, 1);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk); drive(1, op_add, 1, 5'd10, 5'd3, 5'd11, 0); #1;
            chk($sformatf("dbr_stall_c%0d", i), a_stl, 1);
            chk($sformatf("dbr_noflush_c%0d", i), a_fl, 0);
        end
        @(negedge clk); #1;
        chk("dbr_issue", a_iss, 1);
        @(negedge clk); idle(); #1;
        chk("dbr_flush1", a_fl, 1);
        chk("dbr_fcnt", a_fcnt, 3);
        chk("dbr_scnt", a_scnt, 6);
        @(negedge clk); #1;
        chk("dbr_flush2", a_fl, 1);
        arstn = 1'b0; #1;
        chk("mid_rst_flush", a_fl, 0);
        chk("mid_rst_scnt", a_scnt, 0);
        chk("mid_rst_fcnt", a_fcnt, 0);
        @(negedge clk); arstn = 1'b1;
        drive(1, op_add, 0, 5'd11, 5'd10, 5'd12, 0); #1;
        chk("post_rst_nostall", a_stl, 0);
        chk("post_rst_issue", a_iss, 1);

        // saturation: freeze a live hazard with hold
        @(negedge clk); drive(1, op_add, 0, 5'd1, 5'd2, 5'd13, 0); #1;
        chk("sat_wr_issue", a_iss, 1);
        for (int i = 0; i < 21; i++) begin
            @(negedge clk); drive(1, op_add, 0, 5'd13, 5'd1, 5'd14, 1); #1;
            if (i == 0 || i == 20) chk($sformatf("sat_stall_%0d", i), a_stl, 1);
        end
        @(negedge clk); drive(1, op_add, 0, 5'd13, 5'd1, 5'd14, 0); #1;
        chk("sat_d_cnt", d_scnt, 15);
        chk("sat_a_cnt", a_scnt, 21);
        repeat (2) @(negedge clk);
        #1 chk("sat_last_stall", a_stl, 1);
        @(negedge clk); #1;
        chk("sat_issue", a_iss, 1);
        @(negedge clk); idle(); #1;
        chk("sat_d_hold", d_scnt, 15);
        chk("sat_a_final", a_scnt, 24);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller between decode and the register-read stage. It tracks the destination registers of up to PIPE_DEPTH in-flight instructions in a shift-register scoreboard and stalls decode on read-after-write conflicts. It blocks issue and asserts flush for a fixed penalty window after a branch issues. It also keeps saturating stall and flush performance counters.

## Interface
Parameters:
- PIPE_DEPTH, 3: in-flight stages tracked after issue (reg, alu, wb); ≥1.
- HAZ_DEPTH, PIPE_DEPTH: youngest slots compared for RAW conflicts (1..PIPE_DEPTH); smaller values model forwarding.
- BRANCH_PENALTY, 3: flush cycles after a branch issues; ≥1.
- ZERO_REG_EN, 1: register 0 never conflicts and is never recorded.
- CNT_W, 16: perf counter width.

Ports:
- clk  in  1  clock, rising edge.
- arstn  in  1  reset; asynchronous, active-low.
- decode_valid_i  in  1  decode holds an instruction.
- decode_opcode_i  in  alu_opcode_t  op_none = no reads, no write.
- decode_branch_i  in  1  decode instruction is a branch.
- reg_src1_i, reg_src2_i  in  reg_t  source registers.
- reg_dst_i  in  reg_t  destination register.
- pipe_hold_i  in  1  downstream freeze; scoreboard does not advance.
- issue_o  out  1  instruction accepted this cycle.
- stall_o  out  1  RAW conflict is blocking decode.
- flush_o  out  1  branch penalty window active.
- stall_cnt_o, flush_cnt_o  out  CNT_W  saturating counters.

## Operation
- Scoreboard: PIPE_DEPTH slots of {valid, dst}; slot 0 is youngest.
- Each cycle with pipe_hold_i=0:
  - Slots shift toward PIPE_DEPTH-1; the oldest slot is discarded.
  - Slot 0 loads {issue_o && opcode!=op_none && !(ZERO_REG_EN && dst==0), reg_dst_i}.
  - A cycle without issue inserts a bubble (valid=0).
- pipe_hold_i=1: all slots and the FSM counter hold.
- RAW hazard (combinational): decode_valid_i && decode_opcode_i!=op_none && any slot k<HAZ_DEPTH with valid && dst∈{src1,src2}. A source equal to 0 is ignored when ZERO_REG_EN=1.
- stall_o = hazard. issue_o = decode_valid_i && !hazard && !pipe_hold_i && state==IDLE.
- FSM:
  - IDLE → FLUSH on issue_o && decode_branch_i; load cnt=BRANCH_PENALTY-1.
  - FLUSH: flush_o=1 and issue blocked. cnt decrements on cycles without pipe_hold_i. At cnt==0 with no hold, return to IDLE.
- A branch that also has a RAW hazard stalls first; FLUSH is entered only once it issues.
- stall_cnt_o increments on each stall_o cycle. flush_cnt_o increments on each FLUSH entry. Both saturate at all-ones and never wrap.

## Timing
- Reset (async assert, sync-style deassert at the next edge): all slots invalid, state IDLE, cnt 0, issue_o/stall_o/flush_o 0, counters 0.
- Reset mid-FLUSH or mid-stall clears everything immediately. The first cycle after reset can issue.
- hazard, stall_o and issue_o are combinational from inputs and registered state; same-cycle.
- A writer issued at cycle t sits in slot k during cycles t+1+k (no holds). With HAZ_DEPTH=3, a dependent instruction first issues at t+4.
- flush_o is high for exactly BRANCH_PENALTY cycles starting t+1 after a branch issues at t, extended by any hold cycles.
- flush_o and stall_o can both be high; issue_o is 0 in that case.

## Structure
- Reuse alu_opcode_t, reg_t and op_none from decoder_pkg.
- Add hazard_state_t {HZ_IDLE, HZ_FLUSH} and a scoreboard slot struct {valid, dst} to decoder_pkg.
- One sub-module, hazard_scoreboard: the slot shift register plus the match logic, parametrised by PIPE_DEPTH/HAZ_DEPTH. The FSM and counters stay in the top.

## Test plan
- Reset, then an independent stream: add r1←r2,r3, then add r4←r5,r6 → issue_o=1 both cycles, stall_o=0, stall_cnt_o=0.
- Back-to-back RAW, default params: add r1 then add r2←r1,r3 → stall_o=1 for 3 cycles, issue at cycle 4, stall_cnt_o=3. Repeat with HAZ_DEPTH=1 → 1 stall cycle.
- ZERO_REG_EN=1: write r0 then read r0 → no stall. With ZERO_REG_EN=0 → 3 stall cycles.
- Branch at t with BRANCH_PENALTY=3 → flush_o=1 during t+1..t+3, issue_o=0, flush_cnt_o=1. Add pipe_hold_i for 2 cycles mid-window → 5 flush cycles.
- Branch that depends on the previous instruction → stalls first, then issues, then flushes 3 cycles. Bring arstn low mid-FLUSH → flush_o=0 immediately and scoreboard empty.
- Force 2^CNT_W+5 stall cycles → stall_cnt_o holds at all-ones.
